regfile_sb: RTL and testbench

Parametrised integer register file with a per-register pending-write scoreboard, serving the pipelined core's decode and writeback stages. Two read ports, two independent writeback ports (ALU/early and load/late), same-cycle write-to-read bypass, and in-flight write counters that drive decode-stage stall decisions. Replaces the single-write-port register file once multiple writebacks can be outstanding.

---
 rtl/regfile_sb.sv | 122 ++++++++++++
 tb/tb_regfile_sb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Integer register file with two read ports, two writeback ports, same-cycle
// bypass, and a per-register pending-write scoreboard for decode stalls.
module regfile_sb #(
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned SP_IDX  = 2,
  parameter logic [31:0] SP_INIT = 32'h0100_0000,
  parameter int unsigned CWIDTH  = 2,
  localparam int unsigned AWIDTH = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] rs1_i,
  input  logic [AWIDTH-1:0] rs2_i,
  output logic [DWIDTH-1:0] rs1data_o,
  output logic [DWIDTH-1:0] rs2data_o,
  output logic              rs1busy_o,
  output logic              rs2busy_o,
  input  logic              issue_valid_i,
  input  logic [AWIDTH-1:0] issue_rd_i,
  input  logic              wb0_valid_i,
  input  logic [AWIDTH-1:0] wb0_rd_i,
  input  logic [DWIDTH-1:0] wb0_data_i,
  input  logic              wb1_valid_i,
  input  logic [AWIDTH-1:0] wb1_rd_i,
  input  logic [DWIDTH-1:0] wb1_data_i,
  output logic [NREGS-1:0]  pending_o,
  output logic              err_o
);

  localparam int unsigned NW = CWIDTH + 2;
  localparam logic [CWIDTH-1:0] CMAX = '1;

  logic [DWIDTH-1:0] regs_q [NREGS];
  logic [CWIDTH-1:0] cnt_q  [NREGS];
  logic [CWIDTH-1:0] cnt_d  [NREGS];
  logic [NW-1:0]     up     [NREGS];
  logic [NW-1:0]     dn     [NREGS];
  logic [NREGS-1:0]  issue_hit, wb0_hit, wb1_hit, ovf, unf, pend_d;

  // Per-register decode of issue and writeback targets; x0 never matches.
  always_comb begin
    issue_hit = '0;
    wb0_hit   = '0;
    wb1_hit   = '0;
    for (int i = 1; i < NREGS; i++) begin
      issue_hit[i] = issue_valid_i && (issue_rd_i == AWIDTH'(i));
      wb0_hit[i]   = wb0_valid_i   && (wb0_rd_i   == AWIDTH'(i));
      wb1_hit[i]   = wb1_valid_i   && (wb1_rd_i   == AWIDTH'(i));
    end
  end

  // Net counter update with saturation at max and clamping at zero.
  always_comb begin
    ovf    = '0;
    unf    = '0;
    pend_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      up[i]    = NW'(cnt_q[i]) + NW'(issue_hit[i]);
      dn[i]    = NW'(wb0_hit[i]) + NW'(wb1_hit[i]);
      cnt_d[i] = cnt_q[i];
      if (dn[i] > up[i]) begin
        unf[i]   = 1'b1;
        cnt_d[i] = '0;
      end else if ((up[i] - dn[i]) > NW'(CMAX)) begin
        ovf[i]   = 1'b1;
        cnt_d[i] = CMAX;
      end else begin
        cnt_d[i] = CWIDTH'(up[i] - dn[i]);
      end
      pend_d[i] = (cnt_d[i] != '0);
    end
  end

  function automatic logic [DWIDTH-1:0] read_mux(input logic [AWIDTH-1:0] a);
    if (a == '0)                                read_mux = '0;
    else if (wb1_valid_i && (wb1_rd_i == a))    read_mux = wb1_data_i;
    else if (wb0_valid_i && (wb0_rd_i == a))    read_mux = wb0_data_i;
    else                                        read_mux = regs_q[a];
  endfunction

  // Busy once the outstanding count exceeds this cycle's retiring writebacks.
  function automatic logic busy_of(input logic [AWIDTH-1:0] a);
    logic [CWIDTH:0] hits;
    hits = (CWIDTH+1)'(wb0_valid_i && (wb0_rd_i == a))
         + (CWIDTH+1)'(wb1_valid_i && (wb1_rd_i == a));
    busy_of = (a != '0) && ((CWIDTH+1)'(cnt_q[a]) > hits);
  endfunction

  always_comb begin
    rs1data_o = read_mux(rs1_i);
    rs2data_o = read_mux(rs2_i);
    rs1busy_o = busy_of(rs1_i);
    rs2busy_o = busy_of(rs2_i);
  end

  // Register array, wb1 taking priority over wb0 on the same destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= (i == SP_IDX) ? DWIDTH'(SP_INIT) : '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wb1_hit[i])      regs_q[i] <= wb1_data_i;
        else if (wb0_hit[i]) regs_q[i] <= wb0_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
      pending_o <= '0;
      err_o     <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= cnt_d[i];
      pending_o <= pend_d;
      err_o     <= err_o | (|ovf) | (|unf);
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table-driven bench for regfile_sb, plus hand sequences for
// underflow and reset-in-flight.
module tb_regfile_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1, rs2, ird, w0rd, w1rd;
  logic [DW-1:0] rs1d, rs2d, w0d, w1d;
  logic          rs1b, rs2b, iv, w0v, w1v, err;
  logic [NR-1:0] pend;

  int errors = 0;
  int checks = 0;

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .rs1_i(rs1), .rs2_i(rs2),
    .rs1data_o(rs1d), .rs2data_o(rs2d),
    .rs1busy_o(rs1b), .rs2busy_o(rs2b),
    .issue_valid_i(iv), .issue_rd_i(ird),
    .wb0_valid_i(w0v), .wb0_rd_i(w0rd), .wb0_data_i(w0d),
    .wb1_valid_i(w1v), .wb1_rd_i(w1rd), .wb1_data_i(w1d),
    .pending_o(pend), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [AW-1:0] ird;
    logic          w0v;
    logic [AW-1:0] w0rd;
    logic [DW-1:0] w0d;
    logic          w1v;
    logic [AW-1:0] w1rd;
    logic [DW-1:0] w1d;
    logic [AW-1:0] rs1, rs2;
    logic [DW-1:0] e1d;
    logic          e1b;
    logic [DW-1:0] e2d;
    logic          e2b;
    logic [NR-1:0] epend;
    logic          eerr;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(
    input logic iv_, input int ird_,
    input logic w0v_, input int w0rd_, input logic [DW-1:0] w0d_,
    input logic w1v_, input int w1rd_, input logic [DW-1:0] w1d_,
    input int rs1_, input int rs2_,
    input logic [DW-1:0] e1d_, input logic e1b_,
    input logic [DW-1:0] e2d_, input logic e2b_,
    input logic [NR-1:0] epend_, input logic eerr_);
    vec_t v;
    v.iv = iv_;   v.ird = AW'(ird_);
    v.w0v = w0v_; v.w0rd = AW'(w0rd_); v.w0d = w0d_;
    v.w1v = w1v_; v.w1rd = AW'(w1rd_); v.w1d = w1d_;
    v.rs1 = AW'(rs1_); v.rs2 = AW'(rs2_);
    v.e1d = e1d_; v.e1b = e1b_; v.e2d = e2d_; v.e2b = e2b_;
    v.epend = epend_; v.eerr = eerr_;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    iv = v.iv; ird = v.ird;
    w0v = v.w0v; w0rd = v.w0rd; w0d = v.w0d;
    w1v = v.w1v; w1rd = v.w1rd; w1d = v.w1d;
    rs1 = v.rs1; rs2 = v.rs2;
  endtask

  task automatic idle(input int a1, input int a2);
    drive(mk(0,0, 0,0,0, 0,0,0, a1,a2, 0,0,0,0, '0,0));
  endtask

  localparam logic [NR-1:0] B3 = NR'(1) << 3;
  localparam logic [NR-1:0] B5 = NR'(1) << 5;
  localparam logic [NR-1:0] B7 = NR'(1) << 7;
  localparam logic [NR-1:0] B9 = NR'(1) << 9;

  initial begin
    // iv ird  w0v rd data   w1v rd data  rs1 rs2  e1d e1b  e2d e2b  pend err
    tbl.push_back(mk(0,0, 0,0,0,        0,0,0,     2,5, 32'h0100_0000,0, 0,0, '0,0));
    tbl.push_back(mk(1,0, 1,0,32'hDEAD, 0,0,0,     0,0, 0,0, 0,0, '0,0));
    tbl.push_back(mk(1,5, 0,0,0,        0,0,0,     5,0, 0,0, 0,0, '0,0));
    tbl.push_back(mk(0,0, 0,0,0,        0,0,0,     5,0, 0,1, 0,0, B5,0));
    tbl.push_back(mk(0,0, 1,5,32'h1234, 0,0,0,     5,0, 32'h1234,0, 0,0, B5,0));
    tbl.push_back(mk(0,0, 0,0,0,        0,0,0,     5,0, 32'h1234,0, 0,0, '0,0));
    tbl.push_back(mk(1,7, 0,0,0,        0,0,0,     7,0, 0,0, 0,0, '0,0));
    tbl.push_back(mk(1,7, 0,0,0,        0,0,0,     7,0, 0,1, 0,0, B7,0));
    tbl.push_back(mk(0,0, 1,7,32'hA,    0,0,0,     7,0, 32'hA,1, 0,0, B7,0));
    tbl.push_back(mk(0,0, 0,0,0,        1,7,32'hB, 7,0, 32'hB,0, 0,0, B7,0));
    tbl.push_back(mk(0,0, 0,0,0,        0,0,0,     7,9, 32'hB,0, 0,0, '0,0));
    tbl.push_back(mk(1,9, 0,0,0,        0,0,0,     0,9, 0,0, 0,0, '0,0));
    tbl.push_back(mk(1,9, 0,0,0,        0,0,0,     0,9, 0,0, 0,1, B9,0));
    tbl.push_back(mk(0,0, 1,9,32'h11,   1,9,32'h22, 9,9, 32'h22,0, 32'h22,0, B9,0));
    tbl.push_back(mk(0,0, 0,0,0,        0,0,0,     9,0, 32'h22,0, 0,0, '0,0));
    tbl.push_back(mk(1,8, 1,8,32'h55,   0,0,0,     8,0, 32'h55,0, 0,0, '0,0));
    tbl.push_back(mk(0,0, 0,0,0,        0,0,0,     8,0, 32'h55,0, 0,0, '0,0));
    tbl.push_back(mk(1,3, 0,0,0,        0,0,0,     3,0, 0,0, 0,0, '0,0));
    tbl.push_back(mk(1,3, 0,0,0,        0,0,0,     3,0, 0,1, 0,0, B3,0));
    tbl.push_back(mk(1,3, 0,0,0,        0,0,0,     3,0, 0,1, 0,0, B3,0));
    tbl.push_back(mk(1,3, 0,0,0,        0,0,0,     3,0, 0,1, 0,0, B3,0));
    tbl.push_back(mk(0,0, 0,0,0,        0,0,0,     3,0, 0,1, 0,0, B3,1));
    tbl.push_back(mk(0,0, 1,3,32'h1,    0,0,0,     3,0, 32'h1,1, 0,0, B3,1));
    tbl.push_back(mk(0,0, 1,3,32'h2,    0,0,0,     3,0, 32'h2,1, 0,0, B3,1));
    tbl.push_back(mk(0,0, 1,3,32'h3,    0,0,0,     3,0, 32'h3,0, 0,0, B3,1));
    tbl.push_back(mk(0,0, 0,0,0,        0,0,0,     3,2, 32'h3,0, 32'h0100_0000,0, '0,1));

    rst = 1'b1;
    idle(0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (tbl[k]) begin
      drive(tbl[k]);
      #1;
      chk($sformatf("row%0d rs1data", k), 64'(rs1d), 64'(tbl[k].e1d));
      chk($sformatf("row%0d rs1busy", k), 64'(rs1b), 64'(tbl[k].e1b));
      chk($sformatf("row%0d rs2data", k), 64'(rs2d), 64'(tbl[k].e2d));
      chk($sformatf("row%0d rs2busy", k), 64'(rs2b), 64'(tbl[k].e2b));
      chk($sformatf("row%0d pending", k), 64'(pend), 64'(tbl[k].epend));
      chk($sformatf("row%0d err", k),     64'(err),  64'(tbl[k].eerr));
      @(negedge clk);
    end

    // Underflow: writeback to x4 with nothing outstanding.
    rst = 1'b1; idle(0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0,0, 1,4,32'h44, 0,0,0, 4,0, 0,0,0,0, '0,0));
    #1;
    chk("uf bypass", 64'(rs1d), 64'h44);
    chk("uf err_pre", 64'(err), 64'h0);
    @(negedge clk);
    idle(4, 0);
    #1;
    chk("uf err", 64'(err), 64'h1);
    chk("uf stored", 64'(rs1d), 64'h44);
    chk("uf pending", 64'(pend), 64'h0);

    // Reset while x6 is in flight, with a concurrent wb to x6.
    @(negedge clk);
    drive(mk(1,6, 0,0,0, 0,0,0, 6,0, 0,0,0,0, '0,0));
    @(negedge clk);
    idle(6, 0);
    #1;
    chk("rf busy", 64'(rs1b), 64'h1);
    chk("rf pend6", 64'(pend[6]), 64'h1);
    @(negedge clk);
    rst = 1'b1;
    drive(mk(1,6, 1,6,32'h66, 0,0,0, 6,0, 0,0,0,0, '0,0));
    #1;
    chk("rf rst bypass", 64'(rs1d), 64'h66);
    @(negedge clk);
    rst = 1'b0;
    idle(6, 2);
    #1;
    chk("rf x6", 64'(rs1d), 64'h0);
    chk("rf busy6", 64'(rs1b), 64'h0);
    chk("rf sp", 64'(rs2d), 64'h0100_0000);
    chk("rf pending", 64'(pend), 64'h0);
    chk("rf err", 64'(err), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
